// File: rtl/host_if_pkg.sv
// Shared definitions for the host APB slave: FSM states, register offsets
// and CTRL register bit positions.
package host_if_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ENQ_WAIT,
        ST_ENQ,
        ST_KEY_PULSE,
        ST_DEQ_WAIT,
        ST_DEQ,
        ST_CAPTURE,
        ST_RESP,
        ST_ERR
    } host_state_t;

    localparam int ADDR_DATA_IN  = 'h00;
    localparam int ADDR_DATA_OUT = 'h04;
    localparam int ADDR_CTRL     = 'h08;
    localparam int ADDR_STATUS   = 'h0C;
    localparam int ADDR_KEY_IN   = 'h10;

    localparam int CTRL_ENC_BIT = 0;
    localparam int CTRL_DEC_BIT = 1;
    localparam int CTRL_KEY_BIT = 2;

endpackage

// File: rtl/host_wait_timer.sv
// Saturating wait-state counter shared by the RX-full and TX-empty waits;
// done flags that the wait budget has been used up.
module host_wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic n_reset,
    input  logic clear,
    input  logic inc,
    output logic done
);

    localparam int CNT_W = $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_MAX);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

    assign done = (count == CNT_MAX);

endmodule

// File: rtl/host_apb_slave.sv
// Host-facing APB slave: maps register accesses onto RX FIFO enqueues,
// TX FIFO dequeues and one-cycle MCU control pulses.
module host_apb_slave
    import host_if_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    output logic [DATA_W-1:0] rx_wdata,
    output logic              rx_wenable,
    input  logic              fullRx,
    input  logic [DATA_W-1:0] tx_rdata,
    output logic              tx_renable,
    input  logic              emptyTx,
    output logic              key_in,
    output logic              is_encryption_pulse,
    output logic              is_decryption_pulse,
    input  logic [3:0]        status_bits
);

    host_state_t       state;
    host_state_t       state_nxt;
    logic              lat_write;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_data;
    logic [DATA_W-1:0] prdata_q;

    logic timer_clear;
    logic timer_inc;
    logic timer_done;

    logic access;
    logic req_enq;
    logic req_deq;
    logic req_status;
    logic req_ctrl_ok;
    logic lat_ctrl;
    logic lat_key;

    // Exact-offset compares also reject misaligned and out-of-map addresses.
    assign access      = psel && penable;
    assign req_enq     = pwrite && ((paddr == ADDR_W'(ADDR_DATA_IN)) ||
                                    (paddr == ADDR_W'(ADDR_KEY_IN)));
    assign req_deq     = !pwrite && (paddr == ADDR_W'(ADDR_DATA_OUT));
    assign req_status  = !pwrite && (paddr == ADDR_W'(ADDR_STATUS));
    assign req_ctrl_ok = pwrite && (paddr == ADDR_W'(ADDR_CTRL)) &&
                         !(pwdata[CTRL_ENC_BIT] && pwdata[CTRL_DEC_BIT]);

    always_comb begin
        state_nxt   = state;
        timer_clear = 1'b0;
        timer_inc   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (access) begin
                    timer_clear = 1'b1;
                    if (req_enq)
                        state_nxt = fullRx ? ST_ENQ_WAIT : ST_ENQ;
                    else if (req_deq)
                        state_nxt = emptyTx ? ST_DEQ_WAIT : ST_DEQ;
                    else if (req_status || req_ctrl_ok)
                        state_nxt = ST_RESP;
                    else
                        state_nxt = ST_ERR;
                end
            end
            ST_ENQ_WAIT: begin
                if (!psel)           state_nxt = ST_IDLE;
                else if (!fullRx)    state_nxt = ST_ENQ;
                else if (timer_done) state_nxt = ST_ERR;
                else                 timer_inc = 1'b1;
            end
            ST_ENQ:       state_nxt = lat_key ? ST_KEY_PULSE : ST_RESP;
            ST_KEY_PULSE: state_nxt = ST_RESP;
            ST_DEQ_WAIT: begin
                if (!psel)           state_nxt = ST_IDLE;
                else if (!emptyTx)   state_nxt = ST_DEQ;
                else if (timer_done) state_nxt = ST_ERR;
                else                 timer_inc = 1'b1;
            end
            ST_DEQ:       state_nxt = ST_CAPTURE;
            ST_CAPTURE:   state_nxt = ST_RESP;
            ST_RESP:      state_nxt = ST_IDLE;
            ST_ERR:       state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state     <= ST_IDLE;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_data  <= '0;
            prdata_q  <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && access) begin
                lat_write <= pwrite;
                lat_addr  <= paddr;
                lat_data  <= pwdata;
                if (req_status)
                    prdata_q <= DATA_W'(status_bits);
            end
            if (state == ST_CAPTURE)
                prdata_q <= tx_rdata;
        end
    end

    host_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk     (clk),
        .n_reset (n_reset),
        .clear   (timer_clear),
        .inc     (timer_inc),
        .done    (timer_done)
    );

    assign lat_ctrl = lat_write && (lat_addr == ADDR_W'(ADDR_CTRL));
    assign lat_key  = (lat_addr == ADDR_W'(ADDR_KEY_IN));

    assign prdata     = prdata_q;
    assign pready     = (state == ST_RESP) || (state == ST_ERR);
    assign pslverr    = (state == ST_ERR);
    assign rx_wdata   = lat_data;
    assign rx_wenable = (state == ST_ENQ);
    assign tx_renable = (state == ST_DEQ);

    // CTRL pulses fire in the response cycle so an erroring CTRL write never pulses.
    assign key_in              = (state == ST_KEY_PULSE) ||
                                 ((state == ST_RESP) && lat_ctrl && lat_data[CTRL_KEY_BIT]);
    assign is_encryption_pulse = (state == ST_RESP) && lat_ctrl && lat_data[CTRL_ENC_BIT];
    assign is_decryption_pulse = (state == ST_RESP) && lat_ctrl && lat_data[CTRL_DEC_BIT];

endmodule

// File: tb/tb_host_apb_slave.sv
// Randomized scoreboard bench for host_apb_slave: a driver pushes the
// expected response of each APB transfer, a monitor pops on pready.
module tb_host_apb_slave;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int WAIT_MAX = 15;

    logic              clk;
    logic              n_reset;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;
    logic [DATA_W-1:0] rx_wdata;
    logic              rx_wenable;
    logic              fullRx;
    logic [DATA_W-1:0] tx_rdata;
    logic              tx_renable;
    logic              emptyTx;
    logic              key_in;
    logic              is_encryption_pulse;
    logic              is_decryption_pulse;
    logic [3:0]        status_bits;

    host_apb_slave #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .WAIT_MAX (WAIT_MAX)
    ) dut (
        .clk                 (clk),
        .n_reset             (n_reset),
        .psel                (psel),
        .penable             (penable),
        .pwrite              (pwrite),
        .paddr               (paddr),
        .pwdata              (pwdata),
        .prdata              (prdata),
        .pready              (pready),
        .pslverr             (pslverr),
        .rx_wdata            (rx_wdata),
        .rx_wenable          (rx_wenable),
        .fullRx              (fullRx),
        .tx_rdata            (tx_rdata),
        .tx_renable          (tx_renable),
        .emptyTx             (emptyTx),
        .key_in              (key_in),
        .is_encryption_pulse (is_encryption_pulse),
        .is_decryption_pulse (is_decryption_pulse),
        .status_bits         (status_bits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          err;
        int          cycles;
        logic [31:0] prdata;
        int          n_rxw;
        logic [31:0] rxd;
        int          n_key;
        bit          key_order;
        int          n_enc;
        int          n_dec;
        int          n_deq;
    } exp_t;

    exp_t        q[$];
    exp_t        e_mon;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_prdata = '0;

    int          m_cyc = 0, m_nrxw = 0, m_nkey = 0, m_nenc = 0, m_ndec = 0, m_ndeq = 0;
    int          m_rxwcyc = 0, m_keycyc = 0;
    logic [31:0] m_rxd = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!n_reset) begin
            m_cyc = 0; m_nrxw = 0; m_nkey = 0; m_nenc = 0; m_ndec = 0; m_ndeq = 0;
        end else begin
            if (psel && penable) m_cyc++;
            if (rx_wenable) begin m_nrxw++; m_rxd = rx_wdata; m_rxwcyc = m_cyc; end
            if (key_in) begin m_nkey++; m_keycyc = m_cyc; end
            if (is_encryption_pulse) m_nenc++;
            if (is_decryption_pulse) m_ndec++;
            if (tx_renable) m_ndeq++;
            if (rx_wenable && key_in) begin
                errors++;
                $display("FAIL strobe_overlap rx_wenable and key_in together at t=%0t", $time);
            end
            if (pready) begin
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pready with no transfer pending at t=%0t", $time);
                end else begin
                    e_mon = q.pop_front();
                    chk("pslverr", pslverr, e_mon.err);
                    chk("latency", m_cyc, e_mon.cycles);
                    chk("prdata", prdata, e_mon.prdata);
                    chk("rx_wenable_count", m_nrxw, e_mon.n_rxw);
                    if (e_mon.n_rxw == 1 && m_nrxw == 1) chk("rx_wdata", m_rxd, e_mon.rxd);
                    chk("key_in_count", m_nkey, e_mon.n_key);
                    if (e_mon.key_order && m_nkey == 1 && m_nrxw == 1)
                        chk("key_after_enq", m_keycyc, m_rxwcyc + 1);
                    chk("enc_pulse_count", m_nenc, e_mon.n_enc);
                    chk("dec_pulse_count", m_ndec, e_mon.n_dec);
                    chk("tx_renable_count", m_ndeq, e_mon.n_deq);
                end
                m_cyc = 0; m_nrxw = 0; m_nkey = 0; m_nenc = 0; m_ndec = 0; m_ndeq = 0;
            end else if (!psel) begin
                m_cyc = 0;
            end
        end
    end

    // w = number of leading access cycles during which the FIFO flag is held busy.
    task automatic xfer(input logic [4:0] addr, input bit wr, input logic [31:0] wd,
                        input int w, input logic [31:0] trd, input logic [3:0] st);
        exp_t e;
        bit   is_enq, is_key, is_deq, is_status, is_ctrl;
        int   c;
        is_enq    = wr && (addr == 5'h00 || addr == 5'h10);
        is_key    = wr && addr == 5'h10;
        is_deq    = !wr && addr == 5'h04;
        is_status = !wr && addr == 5'h0C;
        is_ctrl   = wr && addr == 5'h08;
        e = '{err: 1'b0, cycles: 2, prdata: m_prdata, n_rxw: 0, rxd: '0, n_key: 0,
              key_order: 1'b0, n_enc: 0, n_dec: 0, n_deq: 0};
        if (is_enq || is_deq) begin
            // IDLE plus WAIT_MAX+1 wait cycles all see the flag busy -> error response
            if (w >= WAIT_MAX + 2) begin
                e.err    = 1'b1;
                e.cycles = WAIT_MAX + 3;
            end else if (is_enq) begin
                e.cycles    = w + 3 + (is_key ? 1 : 0);
                e.n_rxw     = 1;
                e.rxd       = wd;
                e.n_key     = is_key ? 1 : 0;
                e.key_order = is_key;
            end else begin
                e.cycles = w + 4;
                e.n_deq  = 1;
                m_prdata = trd;
                e.prdata = trd;
            end
        end else if (is_status) begin
            m_prdata = {28'd0, st};
            e.prdata = m_prdata;
        end else if (is_ctrl) begin
            if (wd[0] && wd[1]) begin
                e.err = 1'b1;
            end else begin
                e.n_enc = wd[0] ? 1 : 0;
                e.n_dec = wd[1] ? 1 : 0;
                e.n_key = wd[2] ? 1 : 0;
            end
        end else begin
            e.err = 1'b1;
        end
        q.push_back(e);

        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wd;
        tx_rdata = trd; status_bits = st; fullRx = 1'b0; emptyTx = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        c = 1;
        fullRx  = is_enq && (c <= w);
        emptyTx = is_deq && (c <= w);
        forever begin
            @(posedge clk); #1;
            c++;
            fullRx  = is_enq && (c <= w);
            emptyTx = is_deq && (c <= w);
            if (pready) break;
            if (c > 60) begin
                errors++;
                $display("FAIL pready_timeout addr=%0h cycles=%0d required<=60", addr, c);
                q.delete();
                break;
            end
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; fullRx = 1'b0; emptyTx = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_pready"}, pready, 1'b0);
        chk({tag, "_pslverr"}, pslverr, 1'b0);
        chk({tag, "_rx_wenable"}, rx_wenable, 1'b0);
        chk({tag, "_rx_wdata"}, rx_wdata, 32'd0);
        chk({tag, "_tx_renable"}, tx_renable, 1'b0);
        chk({tag, "_key_in"}, key_in, 1'b0);
        chk({tag, "_enc"}, is_encryption_pulse, 1'b0);
        chk({tag, "_dec"}, is_decryption_pulse, 1'b0);
        chk({tag, "_prdata"}, prdata, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [4:0]  a;
        bit          wr;
        logic [31:0] wd;
        int          w;
        n_reset = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
        pwdata = '0; fullRx = 1'b0; emptyTx = 1'b0; tx_rdata = '0; status_bits = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        n_reset = 1'b1;

        xfer(5'h00, 1'b1, 32'hDEADBEEF, 0, 32'h0, 4'h0);
        xfer(5'h10, 1'b1, 32'h01234567, 0, 32'h0, 4'h0);
        xfer(5'h04, 1'b0, 32'h0, 5, 32'hCAFE0001, 4'h0);
        xfer(5'h00, 1'b1, 32'h11112222, 40, 32'h0, 4'h0);
        xfer(5'h04, 1'b0, 32'h0, 40, 32'h77778888, 4'h0);
        xfer(5'h08, 1'b1, 32'h1, 0, 32'h0, 4'h0);
        xfer(5'h08, 1'b1, 32'h3, 0, 32'h0, 4'h0);
        xfer(5'h08, 1'b1, 32'h6, 0, 32'h0, 4'h0);
        xfer(5'h0C, 1'b0, 32'h0, 0, 32'h0, 4'b1010);
        xfer(5'h01, 1'b1, 32'h5, 0, 32'h0, 4'h0);
        xfer(5'h00, 1'b0, 32'h0, 0, 32'h0, 4'h0);
        xfer(5'h14, 1'b1, 32'h9, 0, 32'h0, 4'h0);
        xfer(5'h00, 1'b1, 32'hA5A5A5A5, 16, 32'h0, 4'h0);

        // Reset while stalled on a full RX FIFO.
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; paddr = 5'h00; pwrite = 1'b1;
        pwdata = 32'h5555AAAA; fullRx = 1'b1;
        @(posedge clk); #1;
        penable = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n_reset = 1'b0;
        @(posedge clk); #1;
        check_idle_outputs("midreset");
        psel = 1'b0; penable = 1'b0; fullRx = 1'b0;
        n_reset = 1'b1;
        m_prdata = '0;
        xfer(5'h0C, 1'b0, 32'h0, 0, 32'h0, 4'b0101);

        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 5))
                0: begin a = 5'h00; wr = 1'b1; wd = $urandom; end
                1: begin a = 5'h10; wr = 1'b1; wd = $urandom; end
                2: begin a = 5'h04; wr = 1'b0; wd = $urandom; end
                3: begin a = 5'h0C; wr = 1'b0; wd = $urandom; end
                4: begin a = 5'h08; wr = 1'b1; wd = 32'($urandom_range(0, 7)); end
                default: begin
                    a  = 5'($urandom_range(0, 31));
                    wr = 1'($urandom_range(0, 1));
                    wd = (a == 5'h08) ? 32'($urandom_range(0, 7)) : $urandom;
                end
            endcase
            w = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : 0;
            xfer(a, wr, wd, w, $urandom, 4'($urandom_range(0, 15)));
        end

        repeat (4) @(posedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
